// File: rtl/systolic_tile_sequencer_if.sv
// Command/status and array-control bundle for the systolic tile sequencer.
// master = host/array side driving start and flow control, slave = the sequencer.
interface systolic_tile_sequencer_if #(
  parameter int N   = 2,
  parameter int M   = 2,
  parameter int K_W = 8
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic           start;
  logic [K_W-1:0] k_len;
  logic           feed_stall;
  logic           c_ready;
  logic           busy;
  logic           done;
  logic           mac_clear;
  logic           array_en;
  logic           rd_en;
  logic [K_W-1:0] rd_addr;
  logic [N-1:0]   A_start_en;
  logic [M-1:0]   B_start_en;
  logic           C_write_en;
  logic [CW-1:0]  c_row;

  modport master (
    output start, k_len, feed_stall, c_ready,
    input  busy, done, mac_clear, array_en, rd_en, rd_addr,
           A_start_en, B_start_en, C_write_en, c_row
  );

  modport slave (
    input  start, k_len, feed_stall, c_ready,
    output busy, done, mac_clear, array_en, rd_en, rd_addr,
           A_start_en, B_start_en, C_write_en, c_row
  );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Sequences one output tile: clear, skewed operand feed, drain, row writeback.
// Latency k_len+N+M-2+MAC_LAT+N+2 cycles unstalled; feed_stall freezes FEED, c_ready holds WRITE.
module systolic_tile_sequencer #(
  parameter int N       = 2,
  parameter int M       = 2,
  parameter int K_W     = 8,
  parameter int MAC_LAT = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  systolic_tile_sequencer_if.slave io
);
  localparam int CW        = (N > 1) ? $clog2(N) : 1;
  localparam int DRAIN_LEN = N + M - 2 + MAC_LAT;
  localparam int DW        = $clog2(DRAIN_LEN + 1);
  localparam int AW        = (N > 1) ? N - 1 : 1;
  localparam int BW        = (M > 1) ? M - 1 : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WRITE, S_FIN
  } state_e;

  state_e         state_q, state_d;
  logic [K_W-1:0] k_len_q, k_len_d;
  logic [K_W-1:0] k_cnt_q, k_cnt_d;
  logic [DW-1:0]  drn_q, drn_d;
  logic [CW-1:0]  row_q, row_d;
  logic [AW-1:0]  a_sk_q, a_sk_d;
  logic [BW-1:0]  b_sk_q, b_sk_d;

  logic issue, en, feed_last, drain_last, row_last;

  assign issue      = (state_q == S_FEED) && !io.feed_stall;
  assign en         = (state_q == S_CLEAR) || (state_q == S_DRAIN) || issue;
  assign feed_last  = (k_cnt_q == k_len_q - 1'b1);
  assign drain_last = (drn_q == DW'(DRAIN_LEN - 1));
  assign row_last   = (row_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (io.start) state_d = (io.k_len != '0) ? S_CLEAR : S_FIN;
      S_CLEAR: state_d = S_FEED;
      S_FEED:  if (issue && feed_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_last) state_d = S_WRITE;
      S_WRITE: if (io.c_ready && row_last) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.busy       = (state_q != S_IDLE);
    io.done       = (state_q == S_FIN);
    io.mac_clear  = (state_q == S_CLEAR);
    io.array_en   = en;
    io.rd_en      = issue;
    io.rd_addr    = (state_q == S_FEED) ? k_cnt_q : '0;
    io.A_start_en = N'({a_sk_q, issue});
    io.B_start_en = M'({b_sk_q, issue});
    io.C_write_en = (state_q == S_WRITE);
    io.c_row      = row_q;
  end

  // Skew lanes shift only when the array advances, so stalls freeze the diagonal.
  always_comb begin
    k_len_d = k_len_q;
    if (state_q == S_IDLE && io.start) k_len_d = io.k_len;
    k_cnt_d = k_cnt_q;
    if (state_q == S_CLEAR) k_cnt_d = '0;
    else if (issue)         k_cnt_d = k_cnt_q + 1'b1;
    drn_d = (state_q == S_DRAIN) ? drn_q + 1'b1 : '0;
    row_d = '0;
    if (state_q == S_WRITE) begin
      if (io.c_ready) row_d = row_last ? '0 : row_q + 1'b1;
      else            row_d = row_q;
    end
    a_sk_d = en ? AW'({a_sk_q, issue}) : a_sk_q;
    b_sk_d = en ? BW'({b_sk_q, issue}) : b_sk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_q <= '0;
      k_cnt_q <= '0;
      drn_q   <= '0;
      row_q   <= '0;
      a_sk_q  <= '0;
      b_sk_q  <= '0;
    end else begin
      k_len_q <= k_len_d;
      k_cnt_q <= k_cnt_d;
      drn_q   <= drn_d;
      row_q   <= row_d;
      a_sk_q  <= a_sk_d;
      b_sk_q  <= b_sk_d;
    end
  end
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: directed and random tiles checked against a timeline model.
module tb_systolic_tile_sequencer;
  localparam int N       = 2;
  localparam int M       = 2;
  localparam int K_W     = 4;
  localparam int MAC_LAT = 1;
  localparam int D       = N + M - 2 + MAC_LAT;
  localparam int L       = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_tile_sequencer_if #(.N(N), .M(M), .K_W(K_W)) bus ();

  systolic_tile_sequencer #(.N(N), .M(M), .K_W(K_W), .MAC_LAT(MAC_LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int checks = 0;
  int failures = 0;

  logic st [L];
  logic cr [L];
  int e_busy [L], e_done [L], e_clr [L], e_aen [L], e_rd [L], e_addr [L];
  int e_feed [L], e_cwe [L], e_row [L], e_a [L], e_b [L];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v, input int off);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s off=%0d observed=%0h expected=%0h", tag, off, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0, -1);
    chk({tag, "_done"}, 32'(bus.done), 0, -1);
    chk({tag, "_clr"},  32'(bus.mac_clear), 0, -1);
    chk({tag, "_aen"},  32'(bus.array_en), 0, -1);
    chk({tag, "_rd"},   32'(bus.rd_en), 0, -1);
    chk({tag, "_addr"}, 32'(bus.rd_addr), 0, -1);
    chk({tag, "_A"},    32'(bus.A_start_en), 0, -1);
    chk({tag, "_B"},    32'(bus.B_start_en), 0, -1);
    chk({tag, "_cwe"},  32'(bus.C_write_en), 0, -1);
    chk({tag, "_row"},  32'(bus.c_row), 0, -1);
  endtask

  task automatic pat_clean();
    for (int i = 0; i < L; i++) begin st[i] = 1'b0; cr[i] = 1'b1; end
  endtask

  task automatic pat_random();
    for (int i = 0; i < L; i++) begin
      st[i] = (i < 40) ? ($urandom_range(3) == 0) : 1'b0;
      cr[i] = (i < 40) ? ($urandom_range(3) != 0) : 1'b1;
    end
  endtask

  // Timeline of one tile, offset 0 = the cycle start is presented.
  task automatic build(input int k, output int last);
    int off, issued, row, p, pos;
    for (int i = 0; i < L; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_clr[i] = 0; e_aen[i] = 0; e_rd[i] = 0;
      e_addr[i] = 0; e_feed[i] = 0; e_cwe[i] = 0; e_row[i] = 0; e_a[i] = 0; e_b[i] = 0;
    end
    if (k == 0) begin
      e_busy[1] = 1; e_done[1] = 1; last = 2;
    end else begin
      e_busy[1] = 1; e_clr[1] = 1; e_aen[1] = 1;
      off = 2; issued = 0;
      while (issued < k) begin
        e_busy[off] = 1; e_feed[off] = 1; e_addr[off] = issued;
        if (!st[off]) begin e_rd[off] = 1; e_aen[off] = 1; issued++; end
        off++;
      end
      for (int d = 0; d < D; d++) begin e_busy[off] = 1; e_aen[off] = 1; off++; end
      row = 0;
      while (row < N) begin
        e_busy[off] = 1; e_cwe[off] = 1; e_row[off] = row;
        if (cr[off]) row++;
        off++;
      end
      e_busy[off] = 1; e_done[off] = 1; last = off + 1;
    end
    // Lane i carries the lane-0 value from i enabled cycles earlier; lane 0 is high on
    // enabled-cycle positions 1..k (position 0 is the clear cycle).
    p = 0;
    for (int c = 1; c <= last; c++) begin
      for (int i = 0; i < N; i++) begin
        pos = p - i;
        if (i == 0 ? (e_rd[c] != 0) : (pos >= 1 && pos <= k)) e_a[c] |= (1 << i);
      end
      for (int j = 0; j < M; j++) begin
        pos = p - j;
        if (j == 0 ? (e_rd[c] != 0) : (pos >= 1 && pos <= k)) e_b[c] |= (1 << j);
      end
      p += e_aen[c];
    end
  endtask

  task automatic cmp(input int off);
    chk("busy",       32'(bus.busy),       32'(e_busy[off]), off);
    chk("done",       32'(bus.done),       32'(e_done[off]), off);
    chk("mac_clear",  32'(bus.mac_clear),  32'(e_clr[off]),  off);
    chk("array_en",   32'(bus.array_en),   32'(e_aen[off]),  off);
    chk("rd_en",      32'(bus.rd_en),      32'(e_rd[off]),   off);
    chk("A_start_en", 32'(bus.A_start_en), 32'(e_a[off]),    off);
    chk("B_start_en", 32'(bus.B_start_en), 32'(e_b[off]),    off);
    chk("C_write_en", 32'(bus.C_write_en), 32'(e_cwe[off]),  off);
    if (e_feed[off] != 0) chk("rd_addr", 32'(bus.rd_addr), 32'(e_addr[off]), off);
    if (e_cwe[off] != 0)  chk("c_row",   32'(bus.c_row),   32'(e_row[off]),  off);
  endtask

  task automatic drive(input int off, input int k, input int ign_off);
    @(posedge clk);
    #1;
    bus.start      = (off == 0) || (off == ign_off);
    bus.k_len      = (off == 0) ? K_W'(k) : ((off == ign_off) ? K_W'(5) : '0);
    bus.feed_stall = st[off];
    bus.c_ready    = cr[off];
  endtask

  task automatic run_tile(input int k, input int ign_off, output int done_off);
    int last;
    build(k, last);
    done_off = -1;
    for (int off = 0; off <= last; off++) begin
      drive(off, k, ign_off);
      @(negedge clk);
      cmp(off);
      if (bus.done === 1'b1 && done_off < 0) done_off = off;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.k_len = '0; bus.feed_stall = 1'b0; bus.c_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, last, k;
    bus.start = 1'b0; bus.k_len = '0; bus.feed_stall = 1'b0; bus.c_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    // Nominal tile, k_len=3
    pat_clean();
    run_tile(3, -1, dn);
    chk("nominal_done_cycle", 32'(dn), 10, dn);

    // Feed stall at cycle 3
    pat_clean(); st[3] = 1'b1;
    run_tile(3, -1, dn);
    chk("stall_done_cycle", 32'(dn), 11, dn);

    // Writeback backpressure, c_ready low cycles 8-10
    pat_clean(); cr[8] = 1'b0; cr[9] = 1'b0; cr[10] = 1'b0;
    run_tile(3, -1, dn);
    chk("bp_done_cycle", 32'(dn), 13, dn);

    // Zero-length tile
    pat_clean();
    run_tile(0, -1, dn);
    chk("zero_done_cycle", 32'(dn), 1, dn);

    // Ignored mid-FEED start, then asynchronous reset abort in DRAIN
    pat_clean();
    build(3, last);
    for (int off = 0; off <= 6; off++) begin
      drive(off, 3, 4);
      if (off == 6) begin
        #1 rst_n = 1'b0;
        #1 chk_zero("abort_async");
      end else begin
        @(negedge clk);
        cmp(off);
      end
    end
    bus.start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 0, -1);
      chk("abort_no_busy", 32'(bus.busy), 0, -1);
    end
    rst_n = 1'b1;
    pat_clean();
    run_tile(3, -1, dn);
    chk("after_abort_done_cycle", 32'(dn), 10, dn);

    // Maximum length tile
    pat_clean();
    run_tile(15, -1, dn);
    chk("max_done_cycle", 32'(dn), 15 + N + M - 2 + MAC_LAT + N + 2, dn);

    // Random tiles with random stalls and writeback readiness
    for (int t = 0; t < 12; t++) begin
      k = (t == 0) ? 15 : int'($urandom_range(15));
      pat_random();
      run_tile(k, -1, dn);
      chk("rand_done_seen", 32'(dn > 0), 1, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
- Sequences one output-tile computation on the N x M systolic MAC array.
- Clears the accumulators, then streams k_len operand beats from the A/B operand buffers with per-lane diagonal skew.
- Waits out array drain, then hands the N result rows to the C writeback path under a ready handshake.
- Sits between the host/command logic (start/done) and the MAC array plus operand/result buffers.

Parameters:
- N, 2: array rows; width of A_start_en.
- M, 2: array columns; width of B_start_en.
- K_W, 8: width of k_len and of the operand read address.
- MAC_LAT, 1: MAC cell pipeline latency in cycles; valid range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a tile; sampled only in IDLE.
- k_len  in  K_W  number of inner-product beats; captured with start.
- feed_stall  in  1  operand buffers not ready; freezes FEED progress.
- c_ready  in  1  writeback path accepts a row this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the tile completes.
- mac_clear  out  1  clears all accumulators.
- array_en  out  1  advances the array pipeline.
- rd_en  out  1  operand buffer read strobe.
- rd_addr  out  K_W  operand beat index.
- A_start_en  out  N  per-row injection enables.
- B_start_en  out  M  per-column injection enables.
- C_write_en  out  1  result row valid.
- c_row  out  $clog2(N) (min 1)  row index of the presented result.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; every output and internal counter is 0. Reset asserted mid-tile aborts immediately, with no done pulse.
- FSM states: IDLE, CLEAR, FEED, DRAIN, WRITE, FIN.
- IDLE:
  - start=1 and k_len!=0: latch k_len and go to CLEAR.
  - start=1 and k_len==0: go to FIN. This is a no-op tile with no reads and no writes.
  - start is ignored in every other state.
- CLEAR (1 cycle): mac_clear=1, array_en=1. Then go to FEED with k_cnt=0.
- FEED:
  - When feed_stall=0: rd_en=1, rd_addr=k_cnt, array_en=1, and k_cnt increments.
  - When feed_stall=1: rd_en=0, array_en=0, and k_cnt, the skew registers and rd_addr all hold.
  - Leave for DRAIN in the cycle after the issue where k_cnt==k_len-1.
- Skew:
  - A_start_en[0] = B_start_en[0] = (state==FEED & !feed_stall).
  - Lane i>0 is a register loaded from lane i-1 on every cycle where array_en=1; it holds otherwise.
  - Result: lane i is high for k_len enabled cycles, starting i enabled cycles after lane 0.
  - Outside FEED, lane 0 is 0 and zeros shift through.
- DRAIN: array_en=1, feed_stall is ignored, and a drain counter runs N+M-2+MAC_LAT cycles. Then go to WRITE with c_row=0.
- WRITE:
  - array_en=0 and C_write_en=1 while in WRITE; c_row holds the row index.
  - A row transfers on a cycle where C_write_en & c_ready. On a transfer c_row increments; after row N-1 transfers, go to FIN.
  - c_ready low holds c_row and C_write_en indefinitely.
- FIN (1 cycle): done=1, busy=1. Then go to IDLE.
- All counters are sized to hold their maximum count without wrap. k_len=2^K_W-1 is legal; rd_addr never wraps within a tile.
- Every output is registered or decoded from registered state only; there is no combinational path from inputs to outputs except the feed_stall gating of rd_en, array_en and lane-0 start enables.

Test Plan:
- Nominal, N=M=2, MAC_LAT=1, k_len=3, start at cycle 0, feed_stall=0, c_ready=1:
  - mac_clear at cycle 1.
  - rd_en at cycles 2-4 with rd_addr 0,1,2.
  - A_start_en[0] at cycles 2-4; A_start_en[1] at cycles 3-5.
  - DRAIN at cycles 5-7.
  - C_write_en at cycles 8-9 with c_row 0,1.
  - done at cycle 10; busy at cycles 1-10.
- Stall: same stimulus with feed_stall=1 at cycle 3:
  - Cycle 3 has rd_en=0 and array_en=0, with start enables frozen.
  - rd_addr sequence is 0,1,2 over cycles 2,4,5; done at cycle 11.
- Writeback backpressure: c_ready=0 for cycles 8-10:
  - C_write_en stays high with c_row=0 through cycle 10.
  - Rows transfer at cycles 11 and 12; done at cycle 13.
- Zero length: start with k_len=0:
  - No mac_clear, rd_en or C_write_en.
  - busy and done both high at cycle 1; IDLE at cycle 2.
- Ignored start and reset abort:
  - start pulsed at cycle 4 mid-FEED has no effect.
  - rst_n low at cycle 6 asynchronously zeroes all outputs that same cycle, with no done.
  - A new start after release runs the full nominal sequence.
- Max length, K_W=4, k_len=15: rd_addr runs 0..14 without wrap; total tile latency is 15+N+M-2+MAC_LAT+N+2 cycles.
